// File: rtl/car_dir_detector_if.sv
// car_dir_detector_if: sensor inputs and counter-side outputs of the gate
// direction detector, bundled so the detector and its driver share one bus.
//   master : drives the raw beam sensors, observes the counter controls
//   slave  : the detector itself
interface car_dir_detector_if;
  logic sensor_a;   // raw beam A (street side), 1 = broken, asynchronous
  logic sensor_b;   // raw beam B (lot side),    1 = broken, asynchronous
  logic updown;     // 1 = entry (count up), 0 = exit (count down)
  logic count_en;   // one-cycle count strobe
  logic busy;       // sequence in progress
  logic err;        // one-cycle abort strobe

  modport master (
    output sensor_a,
    output sensor_b,
    input  updown,
    input  count_en,
    input  busy,
    input  err
  );

  modport slave (
    input  sensor_a,
    input  sensor_b,
    output updown,
    output count_en,
    output busy,
    output err
  );
endinterface

// File: rtl/car_dir_detector.sv
// car_dir_detector: synchronises and debounces two in-line beam sensors
// (A street side, B lot side) and decodes the complete break sequence
// A -> AB -> B -> none (entry) or B -> AB -> A -> none (exit) into a one-cycle
// count strobe plus a held direction bit for the occupancy counter.
//
// Optional build macro CAR_DIR_TIMEOUT_EN: when defined, a sequence that
// dwells TIMEOUT cycles in any IN*/OUT* state is aborted (err pulse, no count).
// When undefined, sequence states are held indefinitely.
//
// Parameters:
//   DEBOUNCE : stable cycles before a filtered level follows (1..255)
//   TIMEOUT  : dwell limit per sequence state (timeout build only)
module car_dir_detector #(
  parameter int unsigned DEBOUNCE = 4,
  parameter int unsigned TIMEOUT  = 1000
) (
  input  logic               clk,
  input  logic               reset,
  car_dir_detector_if.slave  bus
);

  // Debounce counter runs 0..DEBOUNCE-1; the mismatch seen with the counter at
  // its last value is the DEBOUNCE-th consecutive one, so the level flips then.
  localparam logic [7:0] DB_LAST = 8'(DEBOUNCE - 1);

  // Elaboration-time parameter sanity checks.
  if ((DEBOUNCE < 1) || (DEBOUNCE > 255)) begin : g_bad_debounce
    $error("car_dir_detector: DEBOUNCE must be in 1..255");
  end
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("car_dir_detector: TIMEOUT must be at least 1");
  end

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_IN1   = 3'd1,
    ST_IN2   = 3'd2,
    ST_IN3   = 3'd3,
    ST_OUT1  = 3'd4,
    ST_OUT2  = 3'd5,
    ST_OUT3  = 3'd6,
    ST_ABORT = 3'd7
  } state_e;

  // ---------------------------------------------------------------------
  // Synchronisers and debounce filters
  // ---------------------------------------------------------------------
  logic       sync1_a_q, sync2_a_q, sync1_b_q, sync2_b_q;
  logic       filt_a_q, filt_b_q;
  logic [7:0] db_cnt_a_q, db_cnt_b_q;

  // Two-flop synchronisers bring the raw beams into the clk domain.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_a_q <= 1'b0;
      sync2_a_q <= 1'b0;
      sync1_b_q <= 1'b0;
      sync2_b_q <= 1'b0;
    end else begin
      sync1_a_q <= bus.sensor_a;
      sync2_a_q <= sync1_a_q;
      sync1_b_q <= bus.sensor_b;
      sync2_b_q <= sync1_b_q;
    end
  end

  // Debounce A: filtered level follows only after DEBOUNCE stable mismatches.
  always_ff @(posedge clk) begin
    if (reset) begin
      filt_a_q   <= 1'b0;
      db_cnt_a_q <= 8'd0;
    end else if (sync2_a_q == filt_a_q) begin
      db_cnt_a_q <= 8'd0;
    end else if (db_cnt_a_q == DB_LAST) begin
      filt_a_q   <= sync2_a_q;
      db_cnt_a_q <= 8'd0;
    end else begin
      db_cnt_a_q <= db_cnt_a_q + 8'd1;
    end
  end

  // Debounce B: same filter as A.
  always_ff @(posedge clk) begin
    if (reset) begin
      filt_b_q   <= 1'b0;
      db_cnt_b_q <= 8'd0;
    end else if (sync2_b_q == filt_b_q) begin
      db_cnt_b_q <= 8'd0;
    end else if (db_cnt_b_q == DB_LAST) begin
      filt_b_q   <= sync2_b_q;
      db_cnt_b_q <= 8'd0;
    end else begin
      db_cnt_b_q <= db_cnt_b_q + 8'd1;
    end
  end

  // ---------------------------------------------------------------------
  // Direction FSM
  // ---------------------------------------------------------------------
  state_e     state_q, state_d;
  logic [1:0] ab_s;
  logic       entry_req_s, exit_req_s;

  assign ab_s = {filt_a_q, filt_b_q};

`ifdef CAR_DIR_TIMEOUT_EN
  localparam int unsigned DW_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [DW_W-1:0] DW_LAST = DW_W'(TIMEOUT - 1);

  logic [DW_W-1:0] dwell_q, dwell_d;
  logic            in_seq_s;

  assign in_seq_s = (state_q != ST_IDLE) && (state_q != ST_ABORT);
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode of the filtered (a,b) pair; unlisted pairs that skip a
  // step of the sequence are treated as illegal and go to ABORT.
  always_comb begin
    state_d     = state_q;
    entry_req_s = 1'b0;
    exit_req_s  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        case (ab_s)
          2'b10:   state_d = ST_IN1;
          2'b01:   state_d = ST_OUT1;
          2'b11:   state_d = ST_ABORT;
          default: state_d = ST_IDLE;
        endcase
      end
      ST_IN1: begin
        case (ab_s)
          2'b11:   state_d = ST_IN2;
          2'b00:   state_d = ST_IDLE;   // backed out, no count
          2'b01:   state_d = ST_ABORT;
          default: state_d = ST_IN1;
        endcase
      end
      ST_IN2: begin
        case (ab_s)
          2'b01:   state_d = ST_IN3;
          2'b10:   state_d = ST_IN1;
          2'b00:   state_d = ST_ABORT;
          default: state_d = ST_IN2;
        endcase
      end
      ST_IN3: begin
        case (ab_s)
          2'b00: begin
            state_d     = ST_IDLE;
            entry_req_s = 1'b1;
          end
          2'b11:   state_d = ST_IN2;
          2'b10:   state_d = ST_ABORT;
          default: state_d = ST_IN3;
        endcase
      end
      ST_OUT1: begin
        case (ab_s)
          2'b11:   state_d = ST_OUT2;
          2'b00:   state_d = ST_IDLE;   // backed out, no count
          2'b10:   state_d = ST_ABORT;
          default: state_d = ST_OUT1;
        endcase
      end
      ST_OUT2: begin
        case (ab_s)
          2'b10:   state_d = ST_OUT3;
          2'b01:   state_d = ST_OUT1;
          2'b00:   state_d = ST_ABORT;
          default: state_d = ST_OUT2;
        endcase
      end
      ST_OUT3: begin
        case (ab_s)
          2'b00: begin
            state_d    = ST_IDLE;
            exit_req_s = 1'b1;
          end
          2'b11:   state_d = ST_OUT2;
          2'b01:   state_d = ST_ABORT;
          default: state_d = ST_OUT3;
        endcase
      end
      ST_ABORT: begin
        if (ab_s == 2'b00) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_ABORT;
        end
      end
      default: state_d = ST_IDLE;
    endcase
`ifdef CAR_DIR_TIMEOUT_EN
    // An expired dwell overrides whatever the sensors asked for.
    if (in_seq_s && (dwell_q == DW_LAST)) begin
      state_d     = ST_ABORT;
      entry_req_s = 1'b0;
      exit_req_s  = 1'b0;
    end else begin
      state_d     = state_d;
    end
`endif
  end

`ifdef CAR_DIR_TIMEOUT_EN
  // Dwell counter next value: restart on every state change, saturate otherwise.
  always_comb begin
    dwell_d = dwell_q;
    if (state_d != state_q) begin
      dwell_d = '0;
    end else if (dwell_q != DW_LAST) begin
      dwell_d = dwell_q + DW_W'(1);
    end else begin
      dwell_d = dwell_q;
    end
  end

  // Dwell counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      dwell_q <= '0;
    end else begin
      dwell_q <= dwell_d;
    end
  end
`endif

  // ---------------------------------------------------------------------
  // Registered outputs
  // ---------------------------------------------------------------------
  logic updown_q, count_en_q, busy_q, err_q;

  // Count strobe, held direction, busy and abort strobe, all from next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      updown_q   <= 1'b1;
      count_en_q <= 1'b0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      count_en_q <= entry_req_s | exit_req_s;
      if (entry_req_s) begin
        updown_q <= 1'b1;
      end else if (exit_req_s) begin
        updown_q <= 1'b0;
      end else begin
        updown_q <= updown_q;
      end
      busy_q <= (state_d != ST_IDLE);
      err_q  <= (state_d == ST_ABORT) && (state_q != ST_ABORT);
    end
  end

  assign bus.updown   = updown_q;
  assign bus.count_en = count_en_q;
  assign bus.busy     = busy_q;
  assign bus.err      = err_q;

endmodule

// File: tb/tb_car_dir_detector.sv
// tb_car_dir_detector: directed, table-driven bench for car_dir_detector with
// DEBOUNCE=2 and TIMEOUT=20. Each table row holds one sensor pattern for a
// number of cycles and states what the counter outputs must show over it.
module tb_car_dir_detector;

  localparam int unsigned DEBOUNCE = 2;
  localparam int unsigned TIMEOUT  = 20;

  logic clk;
  logic reset;

  car_dir_detector_if bus_if ();

  car_dir_detector #(
    .DEBOUNCE (DEBOUNCE),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic a;
    logic b;
    int   cycles;
    int   exp_counts;    // count_en pulses seen over the row
    int   exp_errs;      // err pulses seen over the row
    logic exp_updown;    // updown at the end of the row
    logic exp_busy;      // busy at the end of the row
    logic exp_busy_any;  // busy high at any point in the row
  } vec_t;

  vec_t vecs [24];

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic a, input logic b);
    bus_if.sensor_a = a;
    bus_if.sensor_b = b;
  endtask

  initial begin
    int cnt_pulses;
    int err_pulses;
    int err_at;
    logic busy_any;

    // a, b, cycles, counts, errs, updown, busy_end, busy_any
    // entry
    vecs[0]  = '{1'b1, 1'b0, 10, 0, 0, 1'b1, 1'b1, 1'b1};
    vecs[1]  = '{1'b1, 1'b1, 10, 0, 0, 1'b1, 1'b1, 1'b1};
    vecs[2]  = '{1'b0, 1'b1, 10, 0, 0, 1'b1, 1'b1, 1'b1};
    vecs[3]  = '{1'b0, 1'b0, 10, 1, 0, 1'b1, 1'b0, 1'b1};
    // exit
    vecs[4]  = '{1'b0, 1'b1, 10, 0, 0, 1'b1, 1'b1, 1'b1};
    vecs[5]  = '{1'b1, 1'b1, 10, 0, 0, 1'b1, 1'b1, 1'b1};
    vecs[6]  = '{1'b1, 1'b0, 10, 0, 0, 1'b1, 1'b1, 1'b1};
    vecs[7]  = '{1'b0, 1'b0, 10, 1, 0, 1'b0, 1'b0, 1'b1};
    // entry flips updown back to 1
    vecs[8]  = '{1'b1, 1'b0, 10, 0, 0, 1'b0, 1'b1, 1'b1};
    vecs[9]  = '{1'b1, 1'b1, 10, 0, 0, 1'b0, 1'b1, 1'b1};
    vecs[10] = '{1'b0, 1'b1, 10, 0, 0, 1'b0, 1'b1, 1'b1};
    vecs[11] = '{1'b0, 1'b0, 10, 1, 0, 1'b1, 1'b0, 1'b1};
    // backout
    vecs[12] = '{1'b1, 1'b0, 10, 0, 0, 1'b1, 1'b1, 1'b1};
    vecs[13] = '{1'b0, 1'b0, 10, 0, 0, 1'b1, 1'b0, 1'b1};
    // one-cycle glitch on A is filtered out
    vecs[14] = '{1'b1, 1'b0,  1, 0, 0, 1'b1, 1'b0, 1'b0};
    vecs[15] = '{1'b0, 1'b0, 10, 0, 0, 1'b1, 1'b0, 1'b0};
    // both beams at once: abort, wait for release
    vecs[16] = '{1'b1, 1'b1, 10, 0, 1, 1'b1, 1'b1, 1'b1};
    vecs[17] = '{1'b0, 1'b0, 10, 0, 0, 1'b1, 1'b0, 1'b1};
    // exit after abort, then a normal entry
    vecs[18] = '{1'b0, 1'b1, 10, 0, 0, 1'b1, 1'b1, 1'b1};
    vecs[19] = '{1'b1, 1'b1, 10, 0, 0, 1'b1, 1'b1, 1'b1};
    vecs[20] = '{1'b1, 1'b0, 10, 0, 0, 1'b1, 1'b1, 1'b1};
    vecs[21] = '{1'b0, 1'b0, 10, 1, 0, 1'b0, 1'b0, 1'b1};
    vecs[22] = '{1'b1, 1'b0, 10, 0, 0, 1'b0, 1'b1, 1'b1};
    vecs[23] = '{1'b1, 1'b1, 10, 0, 0, 1'b0, 1'b1, 1'b1};

    drive(1'b0, 1'b0);
    reset = 1'b1;
    repeat (3) tick();

    // Reset values.
    check("rst_updown",   int'(bus_if.updown),   1);
    check("rst_count_en", int'(bus_if.count_en), 0);
    check("rst_busy",     int'(bus_if.busy),     0);
    check("rst_err",      int'(bus_if.err),      0);
    reset = 1'b0;
    repeat (2) tick();

    // Table-driven sequences (rows 22/23 leave a car in IN2, finished below).
    for (int i = 0; i < 24; i++) begin
      drive(vecs[i].a, vecs[i].b);
      cnt_pulses = 0;
      err_pulses = 0;
      busy_any   = 1'b0;
      for (int c = 0; c < vecs[i].cycles; c++) begin
        tick();
        cnt_pulses += int'(bus_if.count_en);
        err_pulses += int'(bus_if.err);
        busy_any   |= bus_if.busy;
      end
      check($sformatf("row%0d_counts", i),   cnt_pulses, vecs[i].exp_counts);
      check($sformatf("row%0d_errs", i),     err_pulses, vecs[i].exp_errs);
      check($sformatf("row%0d_updown", i),   int'(bus_if.updown), int'(vecs[i].exp_updown));
      check($sformatf("row%0d_busy", i),     int'(bus_if.busy),   int'(vecs[i].exp_busy));
      check($sformatf("row%0d_busy_any", i), int'(busy_any),      int'(vecs[i].exp_busy_any));
    end

    // Finish the entry with exact timing: count_en rises 5 cycles after the
    // final release (DEBOUNCE+3), busy falls the same cycle.
    drive(1'b0, 1'b1);
    repeat (10) tick();
    drive(1'b0, 1'b0);
    repeat (4) tick();
    check("lat_pre_count_en", int'(bus_if.count_en), 0);
    check("lat_pre_busy",     int'(bus_if.busy),     1);
    tick();
    check("lat_count_en", int'(bus_if.count_en), 1);
    check("lat_busy",     int'(bus_if.busy),     0);
    check("lat_updown",   int'(bus_if.updown),   1);
    tick();
    check("lat_post_count_en", int'(bus_if.count_en), 0);
    repeat (5) tick();

    // Exit so updown is 0, then reset while an entry sits in IN2.
    drive(1'b0, 1'b1); repeat (10) tick();
    drive(1'b1, 1'b1); repeat (10) tick();
    drive(1'b1, 1'b0); repeat (10) tick();
    drive(1'b0, 1'b0); repeat (10) tick();
    check("pre_rst_updown", int'(bus_if.updown), 0);
    drive(1'b1, 1'b0); repeat (10) tick();
    drive(1'b1, 1'b1); repeat (10) tick();
    check("in2_busy", int'(bus_if.busy), 1);
    reset = 1'b1;
    tick();
    check("midrst_updown",   int'(bus_if.updown),   1);
    check("midrst_count_en", int'(bus_if.count_en), 0);
    check("midrst_busy",     int'(bus_if.busy),     0);
    check("midrst_err",      int'(bus_if.err),      0);
    reset = 1'b0;
    drive(1'b0, 1'b0);
    cnt_pulses = 0;
    err_pulses = 0;
    busy_any   = 1'b0;
    repeat (20) begin
      tick();
      cnt_pulses += int'(bus_if.count_en);
      err_pulses += int'(bus_if.err);
      busy_any   |= bus_if.busy;
    end
    check("postrst_counts",   cnt_pulses,     0);
    check("postrst_errs",     err_pulses,     0);
    check("postrst_busy_any", int'(busy_any), 0);

    // Hold A for 40 cycles: IN1 is entered at cycle 5 (DEBOUNCE+3).
    drive(1'b1, 1'b0);
    cnt_pulses = 0;
    err_pulses = 0;
    err_at     = -1;
    for (int c = 1; c <= 40; c++) begin
      tick();
      cnt_pulses += int'(bus_if.count_en);
      err_pulses += int'(bus_if.err);
      if (bus_if.err && (err_at < 0)) err_at = c;
    end
    check("hold_counts", cnt_pulses, 0);
    check("hold_busy",   int'(bus_if.busy), 1);
`ifdef CAR_DIR_TIMEOUT_EN
    check("hold_errs",   err_pulses, 1);
    check("hold_err_at", err_at, 5 + int'(TIMEOUT));
`else
    check("hold_errs",   err_pulses, 0);
    check("hold_err_at", err_at, -1);
`endif
    drive(1'b0, 1'b0);
    cnt_pulses = 0;
    err_pulses = 0;
    repeat (10) begin
      tick();
      cnt_pulses += int'(bus_if.count_en);
      err_pulses += int'(bus_if.err);
    end
    check("hold_rel_counts", cnt_pulses, 0);
    check("hold_rel_errs",   err_pulses, 0);
    check("hold_rel_busy",   int'(bus_if.busy), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
